// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16-entry synchronous FIFO.
//   DEPTH     : number of storage entries (power of two)
//   PTR_W     : read/write pointer width, wraps naturally at DEPTH
//   CNT_W     : word counter width, holds 0..DEPTH inclusive
//   DEF_WIDTH : default data word width
//   op_t      : accepted-operation encoding driving pointer/count updates
package fifo_pkg;

  localparam int DEPTH     = 16;
  localparam int PTR_W     = 4;
  localparam int CNT_W     = 5;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD,
    OP_WRRD
  } op_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register-array storage with one write port and one
// registered read port. Contents are not reset; only the read register is.
// Ports:
//   clk   : clock
//   rst   : synchronous active-low reset (clears rdata only)
//   we    : write enable, stores wdata at waddr
//   waddr : write address
//   wdata : write data
//   re    : read enable, loads rdata from mem[raddr]
//   raddr : read address
//   rdata : registered read data, holds when re is low
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst && we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read and write to the same entry in one cycle (full, both accepted)
  // returns the old word: no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo16.sv
// Synchronous single-clock 16-entry FIFO with word counter, full/empty,
// almost-full/almost-empty flags and one-cycle overflow/underflow pulses.
// Ports:
//   clk          : clock, all logic on posedge
//   rst          : synchronous active-low reset
//   wr_en, wdata : write request and data
//   rd_en        : read request
//   rdata        : registered read data
//   rvalid       : pulses when rdata holds a freshly read word
//   count        : stored words, 0..16
//   full, empty  : count == DEPTH, count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   overflow     : pulses when a write was rejected
//   underflow    : pulses when a read was rejected
module sync_fifo16 #(
  parameter int WIDTH    = fifo_pkg::DEF_WIDTH,
  parameter int DEPTH    = fifo_pkg::DEPTH,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic [fifo_pkg::CNT_W-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = fifo_pkg::PTR_W;
  localparam int CW = fifo_pkg::CNT_W;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           wr_acc;
  logic           rd_acc;
  fifo_pkg::op_t  op;

  // A full FIFO still accepts a write when a read frees the slot this cycle.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_comb begin
    op = fifo_pkg::OP_NONE;
    if (wr_acc && rd_acc) begin
      op = fifo_pkg::OP_WRRD;
    end else if (wr_acc) begin
      op = fifo_pkg::OP_WR;
    end else if (rd_acc) begin
      op = fifo_pkg::OP_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid    <= rd_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && empty;
      case (op)
        fifo_pkg::OP_WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        fifo_pkg::OP_RD: begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        fifo_pkg::OP_WRRD: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Flags decode straight from the count register, so they change on the
  // same edge as the operation that moved the count.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  fifo_mem #(
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule
